skinny_addconst_seq: RTL and testbench
======================================

SKINNY_ADDCONST_SEQ -- requirements
Module: skinny_addconst_seq

Interface
REQ-001 The block SHALL expose parameter BLOCK_BITS, default 128, which sets the state width; legal values are 64 (4-bit cells) and 128 (8-bit cells).
REQ-002 The block SHALL expose parameter NUM_ROUNDS, default 40, which sets the rounds per block; the legal range is 1..62.
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_state  input  BLOCK_BITS  state before AddConstants.
- in_valid  input  1  in_state, in_first and in_dec are valid.
- in_first  input  1  this beat is round 0 of a new block.
- in_dec  input  1  decryption direction; sampled only when in_first is high.
- in_ready  output  1  the block can accept a beat.
- out_state  output  BLOCK_BITS  state after AddConstants, registered.
- out_valid  output  1  out_state is valid.
- out_ready  input  1  the consumer accepts out_state.
- out_last  output  1  out_state belongs to the final round of the block.
- err  output  1  sticky protocol error.

Function
REQ-004 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both high; out_state SHALL be transferred on a rising edge where out_valid and out_ready are both high.
REQ-005 in_ready SHALL equal (!out_valid | out_ready), giving a single-entry output register with full throughput and a latency of 1 cycle.
REQ-006 The block SHALL keep a 6-bit round-constant register rc, a round counter rnd (0..NUM_ROUNDS), and a direction flag dir.
REQ-007 The forward step SHALL be rc' = {rc[4:0], rc[5]^rc[4]^1}.
REQ-008 The inverse step SHALL be rc' = {rc[0]^rc[5]^1, rc[5:1]}.
REQ-009 RC_LAST SHALL be an elaboration-time constant equal to the constant obtained after NUM_ROUNDS forward steps from 6'h00.
REQ-010 On an accepted beat with in_first=1 and in_dec=0:
- the constant applied is forward(6'h00)=6'h01;
- rc is loaded with 6'h01;
- rnd is set to 1;
- dir is set to 0.
REQ-011 On an accepted beat with in_first=1 and in_dec=1:
- the constant applied is RC_LAST;
- rc is loaded with RC_LAST;
- rnd is set to 1;
- dir is set to 1.
REQ-012 On an accepted beat with in_first=0 and rnd<NUM_ROUNDS:
- the constant applied is forward(rc) when dir=0 and inverse(rc) when dir=1;
- rc takes the applied constant;
- rnd increments.
REQ-013 out_last SHALL be registered with out_state and SHALL be 1 when rnd equals NUM_ROUNDS after the update.
REQ-014 For constant c with BLOCK_BITS=128, out_state SHALL equal in_state with these changes and no others:
- bits [123:120] XOR c[3:0];
- bits [89:88] XOR c[5:4];
- bit 57 inverted.
REQ-015 For constant c with BLOCK_BITS=64, out_state SHALL equal in_state with these changes and no others:
- bits [63:60] XOR c[3:0];
- bits [45:44] XOR c[5:4];
- bit 29 inverted.
REQ-016 If a beat with in_first=0 is accepted while rnd is 0 or NUM_ROUNDS, the block SHALL do all of the following:
- set err;
- pass in_state unmodified;
- set out_last=0;
- leave rc and rnd unchanged.
REQ-017 A beat with in_first=1 accepted mid-block SHALL abandon the current block and restart per REQ-010 or REQ-011, without setting err.
REQ-018 While out_valid=1 and out_ready=0, the block SHALL hold out_state, out_last and out_valid stable and SHALL accept no beat.
REQ-019 err SHALL clear only on reset.

Reset
REQ-020 While rst_n=0 the block SHALL hold these values, and the values SHALL apply immediately without waiting for a clock edge:
- out_valid=0;
- out_last=0;
- out_state=0;
- err=0;
- rc=6'h00;
- rnd=0;
- dir=0.
REQ-021 A reset asserted mid-block or during output stall SHALL discard any pending output.
REQ-022 After rst_n deasserts, the first accepted beat SHALL require in_first=1, otherwise REQ-016 applies.

Verification
REQ-023 Scenario, forward first beat:
- stimulus: BLOCK_BITS=128, in_state=0, in_first=1, in_dec=0;
- response: one cycle later out_state=128'h01000000_00000000_02000000_00000000 with out_valid=1.
REQ-024 Scenario, forward sequence:
- stimulus: BLOCK_BITS=128, zero state, forward, rounds 1..7;
- response: applied constants 01,03,07,0F,1F,3E,3D;
- round 6 out_state=128'h0E000000_03000000_02000000_00000000.
REQ-025 Scenario, decryption:
- stimulus: NUM_ROUNDS=40, a forward block records all constants, then a block with in_dec=1;
- response: the decryption block's constants equal the forward sequence reversed;
- out_last=1 only on beat 40 of each block.
REQ-026 Scenario, stall and overrun:
- stimulus: hold out_ready=0 for 3 cycles;
- response: outputs stable, in_ready=0;
- stimulus: then send a 41st beat with in_first=0;
- response: err=1 and the state passes unmodified.
REQ-027 Scenario, 64-bit:
- stimulus: BLOCK_BITS=64, NUM_ROUNDS=32, in_state=0, first beat;
- response: out_state=64'h1000_0000_2000_0000.
REQ-028 Scenario, reset mid-block:
- stimulus: pulse rst_n low after round 5 of a block;
- response: all outputs clear asynchronously;
- stimulus: a following in_first=1 beat;
- response: the constant applied is 6'h01.

Source files
------------

// File: rtl/skinny_addconst_seq.sv
// SKINNY AddConstants stage with its own round-constant sequencer.
// Single-entry registered output; forward or inverse constant order per block.
module skinny_addconst_seq #(
  parameter int BLOCK_BITS = 128,
  parameter int NUM_ROUNDS = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BLOCK_BITS-1:0] in_state,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_dec,
  output logic                  in_ready,
  output logic [BLOCK_BITS-1:0] out_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  err
);

  localparam int CELL = BLOCK_BITS / 16;

  function automatic logic [5:0] rc_fwd(input logic [5:0] r);
    return {r[4:0], r[5] ^ r[4] ^ 1'b1};
  endfunction

  function automatic logic [5:0] rc_inv(input logic [5:0] r);
    return {r[0] ^ r[5] ^ 1'b1, r[5:1]};
  endfunction

  function automatic logic [5:0] rc_after(input int n);
    logic [5:0] r;
    r = 6'h00;
    for (int i = 0; i < n; i++) r = rc_fwd(r);
    return r;
  endfunction

  // Decryption starts from the constant the forward direction ends on.
  localparam logic [5:0] RC_LAST  = rc_after(NUM_ROUNDS);
  localparam logic [5:0] LAST_RND = 6'(NUM_ROUNDS);

  // c[3:0] into cell 0, c[5:4] into cell 4, fixed 0x2 into cell 8.
  function automatic logic [BLOCK_BITS-1:0] const_mask(input logic [5:0] c);
    logic [BLOCK_BITS-1:0] m;
    m = '0;
    m[BLOCK_BITS-CELL +: 4]     = c[3:0];
    m[BLOCK_BITS-5*CELL +: 2]   = c[5:4];
    m[BLOCK_BITS-9*CELL+1]      = 1'b1;
    return m;
  endfunction

  logic [5:0] rc, rc_nxt, c_apply;
  logic [5:0] rnd, rnd_nxt;
  logic       dir, dir_nxt;
  logic       bad;
  logic       accept;
  logic [BLOCK_BITS-1:0] state_nxt;
  logic       last_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    c_apply = rc_fwd(rc);
    rc_nxt  = rc;
    rnd_nxt = rnd;
    dir_nxt = dir;
    bad     = 1'b0;
    if (in_first) begin
      if (in_dec) begin
        c_apply = RC_LAST;
        dir_nxt = 1'b1;
      end else begin
        c_apply = 6'h01;
        dir_nxt = 1'b0;
      end
      rc_nxt  = c_apply;
      rnd_nxt = 6'd1;
    end else if (rnd == 6'd0 || rnd == LAST_RND) begin
      bad = 1'b1;
    end else begin
      c_apply = dir ? rc_inv(rc) : rc_fwd(rc);
      rc_nxt  = c_apply;
      rnd_nxt = 6'(rnd + 6'd1);
    end
    state_nxt = bad ? in_state : (in_state ^ const_mask(c_apply));
    last_nxt  = !bad && (rnd_nxt == LAST_RND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_state <= '0;
      err       <= 1'b0;
      rc        <= 6'h00;
      rnd       <= 6'd0;
      dir       <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_last  <= last_nxt;
      out_state <= state_nxt;
      err       <= err || bad;
      rc        <= rc_nxt;
      rnd       <= rnd_nxt;
      dir       <= dir_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_skinny_addconst_seq.sv
// Directed bench for skinny_addconst_seq: 128-bit/40-round and 64-bit/32-round instances.
module tb_skinny_addconst_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [127:0] in_state, out_state;
  logic in_valid, in_first, in_dec, in_ready, out_valid, out_ready, out_last, err;

  logic [63:0] s_in_state, s_out_state;
  logic s_in_valid, s_in_first, s_in_dec, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_err;

  skinny_addconst_seq #(.BLOCK_BITS(128), .NUM_ROUNDS(40)) dut (
    .clk(clk), .rst_n(rst_n), .in_state(in_state), .in_valid(in_valid),
    .in_first(in_first), .in_dec(in_dec), .in_ready(in_ready),
    .out_state(out_state), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .err(err));

  skinny_addconst_seq #(.BLOCK_BITS(64), .NUM_ROUNDS(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_state(s_in_state), .in_valid(s_in_valid),
    .in_first(s_in_first), .in_dec(s_in_dec), .in_ready(s_in_ready),
    .out_state(s_out_state), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_last(s_out_last), .err(s_err));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [5:0] m_fwd(input logic [5:0] r);
    return {r[4:0], r[5] ^ r[4] ^ 1'b1};
  endfunction

  function automatic logic [127:0] m_apply(input logic [127:0] s, input logic [5:0] c);
    logic [127:0] m;
    m = 128'd0;
    m[123:120] = c[3:0];
    m[89:88]   = c[5:4];
    m[57]      = 1'b1;
    return s ^ m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [127:0] st, input logic first, input logic dec);
    in_state = st;
    in_first = first;
    in_dec   = dec;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  logic [5:0]   fwd_model [0:40];
  logic [127:0] pat;
  logic [5:0]   got_c;

  initial begin
    rst_n = 1'b0;
    in_state = '0; in_valid = 0; in_first = 0; in_dec = 0; out_ready = 1;
    s_in_state = '0; s_in_valid = 0; s_in_first = 0; s_in_dec = 0; s_out_ready = 1;
    pat = 128'hDEADBEEF_01234567_89ABCDEF_F0E1D2C3;
    fwd_model[0] = 6'h00;
    for (int k = 1; k <= 40; k++) fwd_model[k] = m_fwd(fwd_model[k-1]);

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_state", out_state, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Forward block from the zero state
    for (int k = 1; k <= 40; k++) begin
      beat(128'd0, k == 1, 1'b0);
      if (k == 1) begin
        check("fwd_first_state", out_state, 128'h01000000_00000000_02000000_00000000);
        check("fwd_first_valid", out_valid, 1);
      end
      if (k == 6) check("fwd_round6", out_state, 128'h0E000000_03000000_02000000_00000000);
      if (k == 7) check("fwd_round7", out_state, 128'h0D000000_03000000_02000000_00000000);
      check("fwd_state", out_state, m_apply(128'd0, fwd_model[k]));
      check("fwd_last", out_last, k == 40);
    end
    check("fwd_no_err", err, 0);

    // Stall the 40th output, then push an overrun beat
    out_ready = 1'b0;
    in_state = pat; in_first = 1'b0; in_dec = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_state", out_state, m_apply(128'd0, fwd_model[40]));
      check("stall_valid", out_valid, 1);
      check("stall_last", out_last, 1);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("overrun_err", err, 1);
    check("overrun_state", out_state, pat);
    check("overrun_last", out_last, 0);
    check("overrun_valid", out_valid, 1);

    // Decryption block: constants in reverse order
    for (int k = 1; k <= 40; k++) begin
      beat(128'd0, k == 1, 1'b1);
      got_c = {out_state[89:88], out_state[123:120]};
      check("dec_const", got_c, fwd_model[41-k]);
      check("dec_state", out_state, m_apply(128'd0, fwd_model[41-k]));
      check("dec_last", out_last, k == 40);
    end
    check("err_sticky", err, 1);
    tick();
    check("drain_valid", out_valid, 0);

    // Reset in the middle of a block
    for (int k = 1; k <= 5; k++) beat(pat, k == 1, 1'b0);
    check("mid_round5", out_state, m_apply(pat, 6'h1F));
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_state", out_state, 0);
    check("async_last", out_last, 0);
    check("async_err", err, 0);
    #2 rst_n = 1'b1;
    tick();
    beat(128'd0, 1'b1, 1'b0);
    check("after_rst_const", out_state, m_apply(128'd0, 6'h01));
    beat(pat, 1'b0, 1'b0);
    check("after_rst_r2", out_state, m_apply(pat, 6'h03));

    // Restart mid-block in decrypt direction: no error
    beat(128'd0, 1'b1, 1'b1);
    check("restart_dec", out_state, m_apply(128'd0, fwd_model[40]));
    check("restart_no_err", err, 0);
    beat(128'd0, 1'b0, 1'b0);
    check("restart_dec_r2", out_state, m_apply(128'd0, fwd_model[39]));

    // After reset, a non-first beat is a protocol error
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    beat(pat, 1'b0, 1'b0);
    check("nofirst_err", err, 1);
    check("nofirst_state", out_state, pat);
    check("nofirst_last", out_last, 0);

    // 64-bit instance
    s_in_state = 64'd0; s_in_first = 1'b1; s_in_dec = 1'b0; s_in_valid = 1'b1;
    tick();
    check("s64_first", s_out_state, 64'h1000_0000_2000_0000);
    check("s64_valid", s_out_valid, 1);
    s_in_first = 1'b0;
    tick();
    s_in_valid = 1'b0;
    check("s64_round2", s_out_state, 64'h3000_0000_2000_0000);
    check("s64_err", s_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
